// File: rtl/subterranean_lwc_dout_segmenter_pkg.sv
// Shared encodings for the LWC output segmenter: FSM states, status nibbles and
// header field positions, plus helpers that compose header/status words.
package subterranean_lwc_dout_segmenter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2,
    ST_STATUS = 2'd3
  } state_t;

  localparam logic [3:0] STATUS_SUCCESS = 4'hE;
  localparam logic [3:0] STATUS_FAILURE = 4'hF;

  localparam int HDR_TYPE_LSB = 28;
  localparam int HDR_PARTIAL  = 27;
  localparam int HDR_EOI      = 26;
  localparam int HDR_EOT      = 25;
  localparam int HDR_LAST     = 24;
  localparam int HDR_LEN_LSB  = 0;

  function automatic logic [31:0] header_word(input logic [3:0]  seg_type,
                                              input logic        eot,
                                              input logic        last,
                                              input logic [15:0] len);
    logic [31:0] w;
    w                     = '0;
    w[HDR_TYPE_LSB +: 4]  = seg_type;
    w[HDR_PARTIAL]        = 1'b0;
    w[HDR_EOI]            = 1'b0;
    w[HDR_EOT]            = eot;
    w[HDR_LAST]           = last;
    w[HDR_LEN_LSB +: 16]  = len;
    return w;
  endfunction

  function automatic logic [31:0] status_word(input logic fail);
    return {(fail ? STATUS_FAILURE : STATUS_SUCCESS), 28'h0};
  endfunction

endpackage

// File: rtl/subterranean_lwc_dout_segmenter_if.sv
// Command, core-data and output-stream handshakes of the LWC output segmenter.
// master = the segmenter itself, slave = the core/buffer side driving it.
interface subterranean_lwc_dout_segmenter_if #(
  parameter int W = 32
);
  logic          cmd_status;
  logic          cmd_fail;
  logic [3:0]    cmd_type;
  logic          cmd_eot;
  logic          cmd_last;
  logic [15:0]   cmd_len;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [W-1:0]  din;
  logic          din_valid;
  logic          din_ready;
  logic [W-1:0]  dout;
  logic          dout_last;
  logic          dout_valid;
  logic          dout_ready;

  modport master (
    input  cmd_status, cmd_fail, cmd_type, cmd_eot, cmd_last, cmd_len, cmd_valid,
    input  din, din_valid, dout_ready,
    output cmd_ready, din_ready, dout, dout_last, dout_valid
  );

  modport slave (
    output cmd_status, cmd_fail, cmd_type, cmd_eot, cmd_last, cmd_len, cmd_valid,
    output din, din_valid, dout_ready,
    input  cmd_ready, din_ready, dout, dout_last, dout_valid
  );
endinterface

// File: rtl/subterranean_lwc_dout_segmenter.sv
// Assembles the LWC output stream: header word, zero-padded data words passed
// straight through from the core, or a single status word flagged with dout_last.
module subterranean_lwc_dout_segmenter
  import subterranean_lwc_dout_segmenter_pkg::*;
#(
  parameter int G_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  subterranean_lwc_dout_segmenter_if.master bus
);

  state_t              state_q;
  logic [15:0]         rem_len_q;
  logic [15:0]         rem_len_d;
  logic [15:0]         len_q;
  logic [G_WIDTH-1:0]  word_q;
  logic [G_WIDTH-1:0]  keep_mask;
  logic                cmd_hs;
  logic                out_hs;

  assign cmd_hs    = bus.cmd_valid & bus.cmd_ready;
  assign out_hs    = bus.dout_valid & bus.dout_ready;
  assign rem_len_d = rem_len_q - 16'd4;

  // Tail word of a segment: bytes at or beyond the remaining length read as zero.
  always_comb begin
    keep_mask = '1;
    if (rem_len_q < 16'd4) begin
      unique case (rem_len_q[1:0])
        2'd1:    keep_mask = 32'hFF00_0000;
        2'd2:    keep_mask = 32'hFFFF_0000;
        2'd3:    keep_mask = 32'hFFFF_FF00;
        default: keep_mask = '1;
      endcase
    end
  end

  // Outputs are forced quiet while rst is held, including the IDLE cmd_ready.
  always_comb begin
    bus.cmd_ready  = 1'b0;
    bus.din_ready  = 1'b0;
    bus.dout_valid = 1'b0;
    bus.dout_last  = 1'b0;
    bus.dout       = '0;
    if (!rst) begin
      unique case (state_q)
        ST_IDLE:   bus.cmd_ready = 1'b1;
        ST_HEADER: begin
          bus.dout       = word_q;
          bus.dout_valid = 1'b1;
        end
        ST_DATA:   begin
          bus.dout       = bus.din & keep_mask;
          bus.dout_valid = bus.din_valid;
          bus.din_ready  = bus.dout_ready;
        end
        ST_STATUS: begin
          bus.dout       = word_q;
          bus.dout_valid = 1'b1;
          bus.dout_last  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rem_len_q <= '0;
      len_q     <= '0;
      word_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (cmd_hs) begin
          len_q   <= bus.cmd_len;
          word_q  <= bus.cmd_status ? status_word(bus.cmd_fail)
                                    : header_word(bus.cmd_type, bus.cmd_eot,
                                                  bus.cmd_last, bus.cmd_len);
          state_q <= bus.cmd_status ? ST_STATUS : ST_HEADER;
        end
        ST_HEADER: if (out_hs) begin
          if (len_q == 16'd0) begin
            state_q <= ST_IDLE;
          end else begin
            rem_len_q <= len_q;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: if (out_hs) begin
          if (rem_len_q <= 16'd4) state_q <= ST_IDLE;
          else                    rem_len_q <= rem_len_d;
        end
        ST_STATUS: if (out_hs) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
